// File: rtl/ddr_pkg.sv
// ddr_pkg: DDR command encodings, init FSM state type and counter sizing helper
package ddr_pkg;
  localparam logic [2:0] NOOP = 3'b111;
  localparam logic [2:0] ACTV = 3'b011;
  localparam logic [2:0] READ = 3'b101;
  localparam logic [2:0] WRTE = 3'b100;
  localparam logic [2:0] BTRM = 3'b110;
  localparam logic [2:0] PRCH = 3'b010;
  localparam logic [2:0] ARSR = 3'b001;
  localparam logic [2:0] MRST = 3'b000;
  typedef enum logic [2:0] {CKE_LOW, GAP, ISSUE, TAIL, DONE} state_t;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/ddr_init_rom.sv
// ddr_init_rom: combinational init step table (step in; command/address/bank out), N = 9 + NUM_REFRESH steps
module ddr_init_rom
  import ddr_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int BANK_W = 3,
  parameter int NUM_REFRESH = 2,
  parameter logic [ADDR_W-1:0] MR0_VAL = 'h432,
  parameter logic [ADDR_W-1:0] EMR1_VAL = '0
) (
  input  logic [4:0]        step,
  output logic [2:0]        cmd,
  output logic [ADDR_W-1:0] addr,
  output logic [BANK_W-1:0] bank
);
  localparam logic [ADDR_W-1:0] A10 = ADDR_W'(1) << 10;
  localparam logic [ADDR_W-1:0] MR0_DLL = MR0_VAL | (ADDR_W'(1) << 8);
  localparam logic [ADDR_W-1:0] EMR1_OCD = EMR1_VAL | (ADDR_W'(7) << 7);
  localparam int R = NUM_REFRESH;
  int s;
  assign s = int'(step);
  always_comb begin
    cmd = NOOP;
    addr = A10;
    bank = '0;
    if (s == 0 || s == 5) cmd = PRCH;
    else if (s >= 6 && s < 6 + R) cmd = ARSR;
    else if (s < 9 + R) begin
      cmd = MRST;
      bank = s == 1 ? BANK_W'(2) : s == 2 ? BANK_W'(3) : (s == 4 || s == 6 + R) ? BANK_W'(0) : BANK_W'(1);
      addr = (s == 3 || s == 8 + R) ? EMR1_VAL : s == 4 ? MR0_DLL : s == 6 + R ? MR0_VAL : s == 7 + R ? EMR1_OCD : '0;
    end
  end
endmodule

// File: rtl/ddr_init_seq.sv
// ddr_init_seq: DDR power-up init sequencer; CLK_n/RST(async low) in, CKE/COMMAND_PIN/ADDRESS_PIN/BANK_PIN out, *_USER controller path in, REINIT in, RST_USER/BUSY/STEP status out
module ddr_init_seq
  import ddr_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int BANK_W = 3,
  parameter int RANKS = 1,
  parameter int CKE_DLY = 200,
  parameter int GAP_CYC = 15,
  parameter int NUM_REFRESH = 2,
  parameter int TAIL_CYC = 255,
  parameter logic [ADDR_W-1:0] MR0_VAL = 'h432,
  parameter logic [ADDR_W-1:0] EMR1_VAL = '0
) (
  input  logic              CLK_n,
  input  logic              RST,
  output logic [RANKS-1:0]  CKE,
  output logic [2:0]        COMMAND_PIN,
  output logic [ADDR_W-1:0] ADDRESS_PIN,
  output logic [BANK_W-1:0] BANK_PIN,
  input  logic [2:0]        COMMAND_USER,
  input  logic [ADDR_W-1:0] ADDRESS_USER,
  input  logic [BANK_W-1:0] BANK_USER,
  input  logic              REINIT,
  output logic              RST_USER,
  output logic              BUSY,
  output logic [3:0]        STEP
);
  localparam int N = 9 + NUM_REFRESH;
  localparam int CW = $clog2(max3(CKE_DLY, GAP_CYC, TAIL_CYC) + 1);
  localparam logic [ADDR_W-1:0] A10 = ADDR_W'(1) << 10;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [4:0] step, step_nxt;
  logic cke, cke_nxt, ru_nxt, busy_nxt;
  logic [2:0] cmd_q, rom_cmd;
  logic [ADDR_W-1:0] addr_q, rom_addr;
  logic [BANK_W-1:0] bank_q, rom_bank;
  ddr_init_rom #(
    .ADDR_W(ADDR_W),
    .BANK_W(BANK_W),
    .NUM_REFRESH(NUM_REFRESH),
    .MR0_VAL(MR0_VAL),
    .EMR1_VAL(EMR1_VAL)
  ) u_rom (
    .step(step),
    .cmd(rom_cmd),
    .addr(rom_addr),
    .bank(rom_bank)
  );
  always_comb begin
    nxt = state;
    cnt_nxt = cnt + 1'b1;
    step_nxt = step;
    cke_nxt = cke;
    ru_nxt = RST_USER;
    busy_nxt = BUSY;
    case (state)
      CKE_LOW: if (cnt == CW'(CKE_DLY - 1)) begin
        nxt = GAP;
        cnt_nxt = '0;
        cke_nxt = 1'b1;
      end
      GAP: if (cnt == CW'(GAP_CYC - 1)) begin
        nxt = ISSUE;
        cnt_nxt = '0;
      end
      ISSUE: begin
        cnt_nxt = '0;
        step_nxt = step + 5'd1;
        nxt = int'(step) == N - 1 ? TAIL : GAP;
      end
      TAIL: if (cnt == CW'(TAIL_CYC - 1)) begin
        nxt = DONE;
        cnt_nxt = '0;
        ru_nxt = 1'b1;
        busy_nxt = 1'b0;
      end
      DONE: begin
        cnt_nxt = '0;
        if (REINIT) begin
          nxt = GAP;
          ru_nxt = 1'b0;
          busy_nxt = 1'b1;
          step_nxt = '0;
        end
      end
      default: begin
        nxt = CKE_LOW;
        cnt_nxt = '0;
      end
    endcase
  end
  // command registers are loaded from the table only on the cycle entering ISSUE, so each command lasts exactly one cycle
  always_ff @(posedge CLK_n or negedge RST)
    if (!RST) begin
      state <= CKE_LOW;
      cnt <= '0;
      step <= '0;
      cke <= 1'b0;
      RST_USER <= 1'b0;
      BUSY <= 1'b1;
      cmd_q <= NOOP;
      addr_q <= A10;
      bank_q <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      step <= step_nxt;
      cke <= cke_nxt;
      RST_USER <= ru_nxt;
      BUSY <= busy_nxt;
      cmd_q <= nxt == ISSUE ? rom_cmd : NOOP;
      addr_q <= nxt == ISSUE ? rom_addr : A10;
      bank_q <= nxt == ISSUE ? rom_bank : '0;
    end
  assign CKE = {RANKS{cke}};
  assign COMMAND_PIN = RST_USER ? COMMAND_USER : cmd_q;
  assign ADDRESS_PIN = RST_USER ? ADDRESS_USER : addr_q;
  assign BANK_PIN = RST_USER ? BANK_USER : bank_q;
  assign STEP = step > 5'd15 ? 4'hf : step[3:0];
endmodule

// File: tb/tb_ddr_init_seq.sv
// tb_ddr_init_seq: directed checks of init timing, step table, reinit, reset abort and user passthrough
module tb_ddr_init_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int vectors = 0;
  int errors = 0;
  localparam logic [19:0] NOOP_W = {3'b111, 3'd0, 14'h400};
  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  logic reinit_a = 1'b0, reinit_b = 1'b0, reinit_c = 1'b0;
  logic [2:0] ucmd = 3'b111;
  logic [13:0] uaddr = 14'h400;
  logic [2:0] ubank = 3'd0;
  logic [1:0] cke_a;
  logic [0:0] cke_b, cke_c;
  logic [2:0] cmd_a, cmd_b, cmd_c, bank_a, bank_b, bank_c;
  logic [13:0] addr_a, addr_b, addr_c;
  logic ru_a, ru_b, ru_c, busy_a, busy_b, busy_c;
  logic [3:0] step_a, step_b, step_c;
  ddr_init_seq #(.RANKS(2), .CKE_DLY(4), .GAP_CYC(3), .TAIL_CYC(5), .NUM_REFRESH(2)) dut_a (
    .CLK_n(clk), .RST(rst_a), .CKE(cke_a), .COMMAND_PIN(cmd_a), .ADDRESS_PIN(addr_a), .BANK_PIN(bank_a),
    .COMMAND_USER(ucmd), .ADDRESS_USER(uaddr), .BANK_USER(ubank), .REINIT(reinit_a),
    .RST_USER(ru_a), .BUSY(busy_a), .STEP(step_a));
  ddr_init_seq dut_b (
    .CLK_n(clk), .RST(rst_b), .CKE(cke_b), .COMMAND_PIN(cmd_b), .ADDRESS_PIN(addr_b), .BANK_PIN(bank_b),
    .COMMAND_USER(ucmd), .ADDRESS_USER(uaddr), .BANK_USER(ubank), .REINIT(reinit_b),
    .RST_USER(ru_b), .BUSY(busy_b), .STEP(step_b));
  ddr_init_seq #(.CKE_DLY(4), .GAP_CYC(3), .TAIL_CYC(5), .NUM_REFRESH(4)) dut_c (
    .CLK_n(clk), .RST(rst_c), .CKE(cke_c), .COMMAND_PIN(cmd_c), .ADDRESS_PIN(addr_c), .BANK_PIN(bank_c),
    .COMMAND_USER(ucmd), .ADDRESS_USER(uaddr), .BANK_USER(ubank), .REINIT(reinit_c),
    .RST_USER(ru_c), .BUSY(busy_c), .STEP(step_c));
  function automatic logic [19:0] item(input int k, input int nr);
    if (k == 0 || k == 5) return {3'b010, 3'd0, 14'h400};
    if (k == 1) return {3'b000, 3'd2, 14'h000};
    if (k == 2) return {3'b000, 3'd3, 14'h000};
    if (k == 3) return {3'b000, 3'd1, 14'h000};
    if (k == 4) return {3'b000, 3'd0, 14'h532};
    if (k >= 6 && k < 6 + nr) return {3'b001, 3'd0, 14'h400};
    if (k == 6 + nr) return {3'b000, 3'd0, 14'h432};
    if (k == 7 + nr) return {3'b000, 3'd1, 14'h380};
    return {3'b000, 3'd1, 14'h000};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic walk(input bit sel, input int nr);
    int n;
    int k;
    logic [19:0] exp_w;
    n = 9 + nr;
    for (int e = 1; e <= 4 * n + 9; e++) begin
      if (!sel) reinit_a = e >= 20 && e < 30;
      tick();
      k = (e - 7) / 4;
      exp_w = (e >= 7 && (e - 7) % 4 == 0 && k < n) ? item(k, nr) : NOOP_W;
      chk($sformatf("%s pins e%0d", sel ? "c" : "a", e), sel ? {cmd_c, bank_c, addr_c} : {cmd_a, bank_a, addr_a}, exp_w);
      chk($sformatf("%s cke e%0d", sel ? "c" : "a", e), sel ? {cke_c, cke_c} : cke_a, e >= 4 ? 2'b11 : 2'b00);
      chk($sformatf("%s rst_user e%0d", sel ? "c" : "a", e), sel ? ru_c : ru_a, e == 4 * n + 9);
      if (exp_w != NOOP_W) chk($sformatf("%s step e%0d", sel ? "c" : "a", e), sel ? step_c : step_a, k);
    end
    chk("end step", sel ? step_c : step_a, n);
    chk("end busy", sel ? busy_c : busy_a, 0);
  endtask
  int idx, first_e, last_e, ru_e;
  logic [19:0] seen [11];
  logic [3:0] step4;
  initial begin
    @(negedge clk);
    chk("rst cke", cke_a, 2'b00);
    chk("rst pins", {cmd_a, bank_a, addr_a}, NOOP_W);
    chk("rst status", {ru_a, busy_a, step_a}, 6'b010000);
    rst_a = 1'b1;
    walk(0, 2);
    ucmd = 3'b101;
    uaddr = 14'h0123;
    ubank = 3'd5;
    #1;
    chk("passthrough", {cmd_a, bank_a, addr_a}, {3'b101, 3'd5, 14'h0123});
    ucmd = 3'b111;
    uaddr = 14'h400;
    ubank = 3'd0;
    tick();
    chk("done hold", {ru_a, busy_a, cmd_a, bank_a, addr_a}, {2'b10, NOOP_W});
    reinit_a = 1'b1;
    tick();
    reinit_a = 1'b0;
    chk("reinit status", {ru_a, busy_a, step_a, cke_a}, {2'b01, 4'd0, 2'b11});
    chk("reinit pins", {cmd_a, bank_a, addr_a}, NOOP_W);
    tick();
    tick();
    chk("reinit gap", {cmd_a, bank_a, addr_a}, NOOP_W);
    tick();
    chk("reinit prch", {cmd_a, bank_a, addr_a}, item(0, 2));
    repeat (24) tick();
    chk("step6 arsr", {cmd_a, bank_a, addr_a, step_a}, {item(6, 2), 4'd6});
    rst_a = 1'b0;
    #1;
    chk("abort cke", cke_a, 2'b00);
    chk("abort pins", {cmd_a, bank_a, addr_a}, NOOP_W);
    chk("abort status", {ru_a, busy_a, step_a}, 6'b010000);
    @(negedge clk);
    rst_a = 1'b1;
    walk(0, 2);
    rst_c = 1'b1;
    reinit_c = 1'b1;
    walk(1, 4);
    tick();
    chk("c held reinit", {ru_c, busy_c, step_c, cke_c}, {2'b01, 4'd0, 1'b1});
    reinit_c = 1'b0;
    rst_b = 1'b1;
    idx = 0;
    first_e = -1;
    last_e = -1;
    ru_e = -1;
    step4 = 4'hx;
    for (int e = 1; e <= 1000 && ru_e < 0; e++) begin
      tick();
      if (ru_b) ru_e = e;
      else if (cmd_b != 3'b111 && idx < 11) begin
        seen[idx] = {cmd_b, bank_b, addr_b};
        if (idx == 0) first_e = e;
        if (idx == 4) step4 = step_b;
        last_e = e;
        idx++;
      end
    end
    chk("b count", idx, 11);
    for (int k = 0; k < 11; k++) chk($sformatf("b item%0d", k), k < idx ? seen[k] : 20'hxxxxx, item(k, 2));
    chk("b first edge", first_e, 215);
    chk("b last edge", last_e, 375);
    chk("b step4", step4, 4);
    chk("b rst_user edge", ru_e, 631);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
